pulse_train_controller: RTL and testbench

Sequences a timed square-wave pulse train: a configurable number of high/low periods, each measured in integer ticks of an internal prescaler. Replaces free-running 1 Hz squares where the design needs start/stop control, e.g. LED blink patterns and beeper cadences. A host FSM starts it with a one-cycle `start` and waits for the `done` pulse. All timing uses a single-cycle tick enable, never a derived clock.

---
 rtl/pulse_train_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 34 +++
 rtl/pulse_train_controller.sv | 153 +++++++++++++++
 tb/tb_pulse_train_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train controller: FSM state encoding and
// the prescaler divide-ratio derivation used at elaboration time.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Clock cycles per tick; guarded so a zero tick rate cannot divide by zero.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

    // The tick rate must divide the clock exactly and leave at least two
    // cycles per tick so the prescaler counter has a real terminal count.
    function automatic bit div_valid(input int clk_hz, input int tick_hz);
        if (tick_hz <= 0) begin
            return 1'b0;
        end
        return ((clk_hz % tick_hz) == 0) && ((clk_hz / tick_hz) >= 2);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter that produces a one-cycle tick enable
// on its terminal count. A synchronous clear restarts the count from zero so
// a new train always gets full-length ticks.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count;

    // Count 0..DIV-1 and wrap; reset and clear both restart at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/pulse_train_controller.sv
// Start/stop controlled square-wave sequencer. A train is R repetitions of a
// high phase of H ticks followed by a low phase of L ticks, timed by a
// single-cycle tick enable. All outputs are registered from the next state.
module pulse_train_controller
    import pulse_train_pkg::*;
#(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 1000,
    parameter int CNT_W   = 16,
    parameter int REP_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] high_ticks,
    input  logic [CNT_W-1:0] low_ticks,
    input  logic [REP_W-1:0] repeats,
    input  logic             abort,
    output logic             wave_out,
    output logic             busy,
    output logic             done
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    generate
        if (!div_valid(CLK_HZ, TICK_HZ)) begin : g_bad_div
            $error("pulse_train_controller: CLK_HZ/TICK_HZ must be an exact ratio of at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state, state_d;
    logic [CNT_W-1:0] phase_cnt, phase_d;
    logic [REP_W-1:0] rep_cnt, rep_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             wave_d, busy_d, done_d;
    logic             tick;
    logic             presc_clear;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Next-state, counter and output decode; abort overrides everything.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state;
        phase_d     = phase_cnt;
        rep_d       = rep_cnt;
        high_d      = high_q;
        low_d       = low_q;
        presc_clear = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            presc_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        presc_clear = 1'b1;
                        if ((repeats != '0) && (high_ticks != '0)) begin
                            high_d  = high_ticks;
                            low_d   = low_ticks;
                            phase_d = high_ticks - CNT_ONE;
                            rep_d   = repeats;
                            state_d = HIGH;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end

                HIGH: begin
                    if (tick) begin
                        if (phase_cnt != '0) begin
                            phase_d = phase_cnt - CNT_ONE;
                        end else if (low_q != '0) begin
                            phase_d = low_q - CNT_ONE;
                            state_d = LOW;
                        end else if (rep_cnt != REP_ONE) begin
                            // No low phase: restart the high phase in place.
                            rep_d   = rep_cnt - REP_ONE;
                            phase_d = high_q - CNT_ONE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end

                LOW: begin
                    if (tick) begin
                        if (phase_cnt != '0) begin
                            phase_d = phase_cnt - CNT_ONE;
                        end else if (rep_cnt == REP_ONE) begin
                            state_d = DONE;
                        end else begin
                            rep_d   = rep_cnt - REP_ONE;
                            phase_d = high_q - CNT_ONE;
                            state_d = HIGH;
                        end
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        wave_d = (state_d == HIGH);
        busy_d = (state_d == HIGH) || (state_d == LOW);
        done_d = (state_d == DONE);
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            rep_cnt   <= '0;
            high_q    <= '0;
            low_q     <= '0;
            wave_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            phase_cnt <= phase_d;
            rep_cnt   <= rep_d;
            high_q    <= high_d;
            low_q     <= low_d;
            wave_out  <= wave_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_controller.sv
// Scoreboard bench for pulse_train_controller with DIV = 4. The stimulus
// process pushes the expected {wave_out, busy, done} for every upcoming
// cycle; a monitor pops and compares on each falling edge.
module tb_pulse_train_controller;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 250;
    localparam int DIV     = 4;
    localparam int CNT_W   = 16;
    localparam int REP_W   = 8;
    localparam int NEVER   = 32'h3fff_ffff;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_ticks;
    logic [CNT_W-1:0] low_ticks;
    logic [REP_W-1:0] repeats;
    logic             wave_out;
    logic             busy;
    logic             done;

    pulse_train_controller #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W),
        .REP_W   (REP_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .high_ticks (high_ticks),
        .low_ticks  (low_ticks),
        .repeats    (repeats),
        .abort      (abort),
        .wave_out   (wave_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Edge counter: while cyc == c we are in the interval after edge c.
    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int         cyc;
        logic [2:0] v;
    } exp_t;

    exp_t  sb[$];
    exp_t  cur;
    string tname = "reset";
    int    total = 0;
    int    bad   = 0;

    // Current train description: start sampled at edge d_t0, outputs forced
    // to zero from edge d_kill (abort/reset) onward.
    bit d_active = 1'b0;
    int d_t0     = 0;
    int d_h      = 0;
    int d_l      = 0;
    int d_r      = 0;
    int d_kill   = NEVER;

    // Expected {wave, busy, done} for the interval after edge c. Spec cycle s
    // counts from 1 at the first interval after the start edge.
    function automatic logic [2:0] model(input int c);
        int   s;
        int   p;
        logic w;
        if (!d_active || c < d_t0 || c >= d_kill) begin
            return 3'b000;
        end
        s = c - d_t0 + 1;
        if (d_r == 0 || d_h == 0) begin
            return (s == 1) ? 3'b001 : 3'b000;
        end
        p = (d_h + d_l) * DIV;
        if (s <= d_r * p) begin
            w = (((s - 1) % p) < (d_h * DIV));
            return {w, 2'b10};
        end
        if (s == d_r * p + 1) begin
            return 3'b001;
        end
        return 3'b000;
    endfunction

    task automatic check(input string name, input int c, input logic [2:0] act,
                         input logic [2:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle %0d: wave/busy/done got %b want %b", name, c, act, expv);
        end
    endtask

    // Monitor: compare the DUT against the scoreboard entry for this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %s stale entry for cycle %0d at cycle %0d", tname, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            cur = sb.pop_front();
            check(tname, cyc, {wave_out, busy, done}, cur.v);
        end
    end

    // Push the expectation for the interval after the next edge, then step.
    task automatic advance();
        exp_t e;
        e.cyc = cyc + 1;
        e.v   = model(cyc + 1);
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) advance();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) advance();
    endtask

    // Issue a start from IDLE that the DUT is expected to accept.
    task automatic begin_train(input int h, input int l, input int r);
        high_ticks = CNT_W'(h);
        low_ticks  = CNT_W'(l);
        repeats    = REP_W'(r);
        start      = 1'b1;
        d_active   = 1'b1;
        d_t0       = cyc + 1;
        d_h        = h;
        d_l        = l;
        d_r        = r;
        d_kill     = NEVER;
        advance();
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        high_ticks = '0;
        low_ticks  = '0;
        repeats    = '0;
        run(3);
        reset = 1'b0;
        run(3);

        // Basic train: high 1-8, low 9-12, high 13-20, low 21-24, done 25.
        tname = "t1_h2l1r2";
        begin_train(2, 1, 2);
        wait_until(d_t0 + 30);

        // Zero low phase: solid high 1-24 with no glitch, done 25.
        tname = "t2_h3l0r2";
        begin_train(3, 0, 2);
        wait_until(d_t0 + 28);

        // Degenerate configs: done at cycle 1, nothing else.
        tname = "t3_r0";
        begin_train(2, 1, 0);
        run(4);
        tname = "t3_h0";
        begin_train(0, 1, 3);
        run(4);

        // Abort in spec cycle 5, restart in spec cycle 10.
        tname = "t4_abort";
        begin_train(2, 2, 3);
        wait_until(d_t0 + 4);
        abort  = 1'b1;
        d_kill = cyc + 1;
        advance();
        wait_until(d_t0 + 9);
        tname = "t4_restart";
        begin_train(2, 2, 3);
        wait_until(d_t0 + 3 * 16 + 4);

        // Start during a running train is ignored, as are input changes.
        tname = "t5_ignore";
        begin_train(2, 1, 2);
        wait_until(d_t0 + 2);
        high_ticks = 16'd5;
        low_ticks  = 16'd5;
        repeats    = 8'd9;
        start      = 1'b1;
        advance();
        wait_until(d_t0 + 30);

        // Abort and start together in IDLE: nothing starts.
        tname      = "t5_abort_start";
        high_ticks = 16'd2;
        low_ticks  = 16'd1;
        repeats    = 8'd2;
        start      = 1'b1;
        abort      = 1'b1;
        d_kill     = cyc + 1;
        advance();
        run(10);

        // Reset in spec cycle 6 clears everything; a new start is clean.
        tname = "t6_reset";
        begin_train(2, 1, 2);
        wait_until(d_t0 + 5);
        reset  = 1'b1;
        d_kill = cyc + 1;
        advance();
        reset = 1'b0;
        run(2);
        tname = "t6_after";
        begin_train(2, 1, 2);
        wait_until(d_t0 + 30);

        @(negedge clock);
        @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
